yhat_out_sram: RTL and testbench
================================

# yhat_out_sram

Output-side result buffer for the RNN wave predictor. Captures each prediction word the RNN core emits with `yhat_valid` into an on-chip SRAM until a full frame of `MAX_ADDR+1` results is stored. On a host `read_start` it drains the frame over a valid/ready stream, then raises a sticky interrupt until `int_clear`. It is the read-back counterpart of the input sample buffer: that buffer feeds samples into the core, this one collects the core's outputs.

## Interface
- `DATA_WIDTH`, 16, width of a prediction word.
- `ADDR_DEPTH`, 9, address and counter width.
- `MAX_ADDR`, 499, index of the last word in a frame; frame length is `MAX_ADDR+1`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `yhat_valid`  in  1  single-cycle strobe from the RNN core; `yhat_in` is valid on it.
- `yhat_in`  in  `DATA_WIDTH`  prediction word.
- `read_start`  in  1  host pulse that starts the drain.
- `out_ready`  in  1  host can accept a beat.
- `int_clear`  in  1  host clears the interrupt and overflow, and re-arms the block.
- `out_valid`  out  1  `data_out` is presented.
- `data_out`  out  `DATA_WIDTH`  drained word, registered.
- `out_last`  out  1  marks the beat carrying index `MAX_ADDR`.
- `full`  out  1  frame captured and not yet fully drained.
- `irq`  out  1  drain complete, sticky.
- `overflow`  out  1  sticky: a `yhat_valid` arrived while not in FILL.
- `wr_count`  out  `ADDR_DEPTH`  words captured in the current frame.

## Operation
- States:
  - FILL: reset state.
  - FULL_WAIT.
  - RD_FETCH.
  - RD_VALID.
  - DONE.
- FILL, on `yhat_valid`:
  - write `yhat_in` to `ram[wr_addr]`;
  - `wr_addr` and `wr_count` increment.
  - If the write was at `wr_addr == MAX_ADDR`, go to FULL_WAIT, set `full=1`, and clear `wr_addr`.
- FULL_WAIT:
  - wait for `read_start`, then clear `rd_addr` and go to RD_FETCH.
  - `read_start` in any other state is ignored.
- RD_FETCH:
  - SRAM read of `ram[rd_addr]` is issued, then go to RD_VALID.
- RD_VALID:
  - `data_out` holds the fetched word and `out_valid=1`.
  - `out_last = (rd_addr == MAX_ADDR)`.
  - On `out_valid && out_ready` with `rd_addr != MAX_ADDR`: `rd_addr+1`, go to RD_FETCH.
  - If that beat was the last: go to DONE with `full=0` and `irq=1`.
  - `data_out`, `out_valid` and `out_last` hold stable while `out_ready=0`.
- DONE:
  - `irq` stays high.
  - On `int_clear`: `irq=0`, `overflow=0`, `wr_count=0`, go to FILL.
- Overflow:
  - `yhat_valid` in any state other than FILL sets `overflow`.
  - The word is dropped and the RAM is not written.
- `int_clear` outside DONE clears `overflow` only; the state is unchanged.
- Only one SRAM access happens per cycle. Write happens only in FILL and read only in RD_FETCH, so a single-port array suffices.
- Address arithmetic is unsigned `ADDR_DEPTH` bits. Wrap never occurs because addresses clear at `MAX_ADDR`.

## Timing
- Reset values:
  - state FILL;
  - `wr_addr`, `rd_addr`, `wr_count` = 0;
  - `out_valid`, `out_last`, `full`, `irq`, `overflow` = 0;
  - `data_out` = 0.
  - RAM contents are not reset.
- Capture takes effect in the same edge as `yhat_valid`. `wr_count` reflects the word on the next cycle.
- `full` rises the cycle after the `MAX_ADDR` write.
- Drain start: `read_start` at edge N gives RD_FETCH in cycle N+1 and `out_valid` in cycle N+2.
- Throughput: one beat per 2 cycles with `out_ready` held high. `out_valid` deasserts for one cycle between beats.
- `irq` rises the cycle after the final handshake.
- Simultaneous `yhat_valid` and `read_start` in FULL_WAIT: the drain starts and `overflow` is set.
- Reset mid-operation aborts at once to FILL with all outputs at reset values. A partial frame is discarded and its RAM contents are stale.

## Structure
- Package `rnn_io_pkg`:
  - state encoding constants (3-bit);
  - default `DATA_WIDTH`, `ADDR_DEPTH`, `MAX_ADDR`, shared with the input sample buffer.
- Sub-module `sp_sram`: single-port, synchronous read with 1-cycle latency, write-enable, depth `MAX_ADDR+1`. It is reusable by the input buffer.
- Top level holds the FSM, address counters, flag registers and the output register.

## Test plan
- Fill and drain:
  - 500 `yhat_valid` strobes with `yhat_in = 3*i`, then `full=1` and `wr_count=500`.
  - `read_start` with `out_ready=1` gives 500 beats of `data_out = 3*k`, one every 2 cycles.
  - `out_last` is high only on k=499, and `irq=1` the cycle after.
- Backpressure: hold `out_ready=0` for 7 cycles on beat 10. `data_out=30`, `out_valid` and `out_last=0` stay stable, and there is no skip or duplicate when released.
- Overflow:
  - A `yhat_valid` of 0xBEEF in FULL_WAIT sets `overflow=1`.
  - The drained frame is unchanged, with no 0xBEEF present.
  - `int_clear` in FULL_WAIT clears `overflow` while the state stays FULL_WAIT.
- Re-arm: `int_clear` in DONE gives `irq=0`, `wr_count=0`, state FILL. A second frame of `0x1000+i` drains correctly.
- Ignored start: `read_start` during FILL after 100 words has no effect, and filling continues to 500.
- Reset mid-drain: assert `rst_n=0` at beat 250. All outputs return to 0. A new 500-word fill then drains correctly from index 0.

Source files
------------

// File: rtl/rnn_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_io_pkg
//  Description : Shared defaults and FSM state encoding for the RNN I/O
//                sample and result buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rnn_io_pkg;

    // Frame geometry shared by the input sample buffer and the result buffer
    localparam int DFLT_DATA_WIDTH = 16;
    localparam int DFLT_ADDR_DEPTH = 9;
    localparam int DFLT_MAX_ADDR   = 499;

    // Result-buffer control states
    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_FULL_WAIT = 3'd1,
        ST_RD_FETCH  = 3'd2,
        ST_RD_VALID  = 3'd3,
        ST_DONE      = 3'd4
    } buf_state_e;

endpackage : rnn_io_pkg
`default_nettype wire

// File: rtl/sp_sram.sv
`default_nettype none
// ============================================================================
//  Module      : sp_sram
//  Description : Single-port synchronous SRAM, one access per cycle.
//                Read data appears one cycle after an enabled read and is
//                held until the next enabled read. The read-data register
//                is reset; the array itself is not.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_sram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-data register: loads only on an enabled read, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sp_sram
`default_nettype wire

// File: rtl/yhat_out_sram.sv
`default_nettype none
// ============================================================================
//  Module      : yhat_out_sram
//  Description : Result buffer for the RNN wave predictor. Captures one frame
//                of prediction words into SRAM, drains it to the host over a
//                valid/ready stream on read_start, then raises a sticky irq
//                until int_clear re-arms the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module yhat_out_sram
    import rnn_io_pkg::*;
#(
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
    parameter int ADDR_DEPTH = DFLT_ADDR_DEPTH,
    parameter int MAX_ADDR   = DFLT_MAX_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  yhat_valid,
    input  logic [DATA_WIDTH-1:0] yhat_in,
    input  logic                  read_start,
    input  logic                  out_ready,
    input  logic                  int_clear,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_last,
    output logic                  full,
    output logic                  irq,
    output logic                  overflow,
    output logic [ADDR_DEPTH-1:0] wr_count
);

    localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = ADDR_DEPTH'(MAX_ADDR);
    localparam logic [ADDR_DEPTH-1:0] ADDR_ONE  = ADDR_DEPTH'(1);

    buf_state_e            state_q,     state_d;
    logic [ADDR_DEPTH-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_DEPTH-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_DEPTH-1:0] wr_count_q,  wr_count_d;
    logic                  full_q,      full_d;
    logic                  irq_q,       irq_d;
    logic                  overflow_q,  overflow_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;

    // SRAM port controls; write only in FILL, read only in RD_FETCH
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_DEPTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // The SRAM read-data register doubles as the data_out register: it loads
    // only on the RD_FETCH read, so it holds the beat stable under backpressure
    sp_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_DEPTH),
        .DEPTH      (MAX_ADDR + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (yhat_in),
        .rdata_o (ram_rdata)
    );

    // Next-state, counter, flag and SRAM-control decode
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_count_d = wr_count_q;
        full_d     = full_q;
        irq_d      = irq_q;
        overflow_d = overflow_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = wr_addr_q;

        unique case (state_q)
            ST_FILL: begin
                if (yhat_valid) begin
                    ram_en     = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = wr_addr_q;
                    wr_count_d = wr_count_q + ADDR_ONE;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        full_d    = 1'b1;
                        state_d   = ST_FULL_WAIT;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end
            end
            ST_FULL_WAIT: begin
                if (read_start) begin
                    rd_addr_d = '0;
                    state_d   = ST_RD_FETCH;
                end
            end
            ST_RD_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = rd_addr_q;
                state_d  = ST_RD_VALID;
            end
            ST_RD_VALID: begin
                if (out_ready) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        full_d  = 1'b0;
                        irq_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                        state_d   = ST_RD_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (int_clear) begin
                    irq_d      = 1'b0;
                    wr_count_d = '0;
                    state_d    = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // int_clear clears overflow in every state; a word dropped in the
        // same cycle still sets it so the loss is never hidden
        if (int_clear) begin
            overflow_d = 1'b0;
        end
        if (yhat_valid && (state_q != ST_FILL)) begin
            overflow_d = 1'b1;
        end

        // Stream flags are registered from the next state so they line up
        // with the SRAM read data that arrives on entry to RD_VALID
        out_valid_d = (state_d == ST_RD_VALID);
        out_last_d  = out_valid_d && (rd_addr_d == LAST_ADDR);
    end

    // State, counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_count_q  <= '0;
            full_q      <= 1'b0;
            irq_q       <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_count_q  <= wr_count_d;
            full_q      <= full_d;
            irq_q       <= irq_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign data_out  = ram_rdata;
    assign full      = full_q;
    assign irq       = irq_q;
    assign overflow  = overflow_q;
    assign wr_count  = wr_count_q;

endmodule : yhat_out_sram
`default_nettype wire

// File: tb/tb_yhat_out_sram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_yhat_out_sram
//  Description : Scoreboard bench for yhat_out_sram: fill/drain, backpressure,
//                overflow, re-arm, ignored start and reset mid-drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_yhat_out_sram;

    localparam int NW = 500;

    logic        clk;
    logic        rst_n;
    logic        yhat_valid;
    logic [15:0] yhat_in;
    logic        read_start;
    logic        out_ready;
    logic        int_clear;
    logic        out_valid;
    logic [15:0] data_out;
    logic        out_last;
    logic        full;
    logic        irq;
    logic        overflow;
    logic [8:0]  wr_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];

    yhat_out_sram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .yhat_valid (yhat_valid),
        .yhat_in    (yhat_in),
        .read_start (read_start),
        .out_ready  (out_ready),
        .int_clear  (int_clear),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .out_last   (out_last),
        .full       (full),
        .irq        (irq),
        .overflow   (overflow),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int kind, input int i);
        logic [15:0] v;
        v = 16'(i);
        case (kind)
            0:       return 16'(3 * i);
            1:       return 16'h1000 + v;
            2:       return 16'(7 * i + 5);
            default: return v ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_valid"},    32'(out_valid), 32'd0);
        chk_eq({tag, "_last"},     32'(out_last),  32'd0);
        chk_eq({tag, "_data"},     32'(data_out),  32'd0);
        chk_eq({tag, "_full"},     32'(full),      32'd0);
        chk_eq({tag, "_irq"},      32'(irq),       32'd0);
        chk_eq({tag, "_overflow"}, 32'(overflow),  32'd0);
        chk_eq({tag, "_wr_count"}, 32'(wr_count),  32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
    endtask

    // Fill one frame; optionally pulse read_start alongside word ign_at
    task automatic fill(input int kind, input int ign_at);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            if (ign_at >= 0 && i == ign_at + 2) begin
                chk_eq("ign_start_valid", 32'(out_valid), 32'd0);
                chk_eq("ign_start_count", 32'(wr_count), 32'(i));
            end
            if (i == NW - 1) begin
                chk_eq("fill_full_early", 32'(full), 32'd0);
                chk_eq("fill_count_499", 32'(wr_count), 32'(NW - 1));
            end
            yhat_valid = 1'b1;
            yhat_in    = word_of(kind, i);
            read_start = (i == ign_at);
            exp_q.push_back(word_of(kind, i));
        end
        @(negedge clk);
        yhat_valid = 1'b0;
        read_start = 1'b0;
        chk_eq("fill_full", 32'(full), 32'd1);
        chk_eq("fill_count", 32'(wr_count), 32'(NW));
    endtask

    // Drain one frame; optional stall beat, reset abort beat, and a
    // simultaneous dropped word on the read_start cycle
    task automatic drain(input int stall_beat, input int abort_at, input bit ovf_start);
        int k = 0;
        int stall = 0;
        int cyc = 0;
        int last_cyc = 0;
        bit aborted = 1'b0;
        logic [15:0] e;
        @(negedge clk);
        read_start = 1'b1;
        if (ovf_start) begin
            yhat_valid = 1'b1;
            yhat_in    = 16'hBEEF;
        end
        @(negedge clk);
        read_start = 1'b0;
        yhat_valid = 1'b0;
        chk_eq("start_n1_valid", 32'(out_valid), 32'd0);
        if (ovf_start) chk_eq("ovf_simul_start", 32'(overflow), 32'd1);
        @(negedge clk);
        chk_eq("start_n2_valid", 32'(out_valid), 32'd1);
        while (k < NW && cyc < 5000) begin
            if (k == abort_at && out_valid) begin
                rst_n = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (out_valid && k == stall_beat && stall < 7) begin
                out_ready = 1'b0;
                stall++;
                chk_eq("stall_data", 32'(data_out), 32'(exp_q[0]));
                chk_eq("stall_last", 32'(out_last), 32'd0);
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    e = exp_q.pop_front();
                    chk_eq($sformatf("beat%0d_data", k), 32'(data_out), 32'(e));
                    chk_eq($sformatf("beat%0d_last", k), 32'(out_last), 32'(k == NW - 1));
                    if (k > 0 && k != stall_beat)
                        chk_eq($sformatf("beat%0d_gap", k), 32'(cyc - last_cyc), 32'd2);
                    if (k == NW - 1) chk_eq("irq_early", 32'(irq), 32'd0);
                    last_cyc = cyc;
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        if (aborted) begin
            #1;
            chk_all_zero("abort_rst");
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk_eq("drain_beats", 32'(k), 32'(NW));
            chk_eq("done_irq", 32'(irq), 32'd1);
            chk_eq("done_full", 32'(full), 32'd0);
            chk_eq("done_valid", 32'(out_valid), 32'd0);
            chk_eq("done_queue_empty", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        yhat_valid = 1'b0;
        yhat_in    = '0;
        read_start = 1'b0;
        out_ready  = 1'b1;
        int_clear  = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Frame 1: 3*i, read_start ignored during fill, stall on beat 10
        fill(0, 100);
        drain(10, -1, 1'b0);
        pulse_clear();
        chk_eq("rearm_irq", 32'(irq), 32'd0);
        chk_eq("rearm_count", 32'(wr_count), 32'd0);
        chk_eq("rearm_full", 32'(full), 32'd0);

        // Frame 2: 0x1000+i, dropped word in FULL_WAIT, clear, drain
        fill(1, -1);
        @(negedge clk);
        yhat_valid = 1'b1;
        yhat_in    = 16'hBEEF;
        @(negedge clk);
        yhat_valid = 1'b0;
        chk_eq("ovf_set", 32'(overflow), 32'd1);
        chk_eq("ovf_count", 32'(wr_count), 32'(NW));
        chk_eq("ovf_full", 32'(full), 32'd1);
        pulse_clear();
        chk_eq("ovf_cleared", 32'(overflow), 32'd0);
        chk_eq("ovf_clr_full", 32'(full), 32'd1);
        chk_eq("ovf_clr_irq", 32'(irq), 32'd0);
        drain(-1, -1, 1'b1);
        pulse_clear();
        chk_eq("clr2_overflow", 32'(overflow), 32'd0);
        chk_eq("clr2_irq", 32'(irq), 32'd0);

        // Frame 3 aborted by reset mid-drain, frame 4 drains from index 0
        fill(2, -1);
        drain(-1, 250, 1'b0);
        fill(3, -1);
        drain(-1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_yhat_out_sram
`default_nettype wire
